ram_loader: RTL and testbench

- Writes a full 16-byte program image into the computer's 16x8 RAM from a byte stream (valid/ready), then optionally reads it back and checks it against a load-time checksum.
- Sits between the programming front end (switches/UART byte source) and the RAM's write/read port.
- Holds the CPU halted while it owns the RAM.

---
 rtl/ram_loader_pkg.sv | 19 +
 rtl/ram_loader_if.sv | 38 +++
 rtl/ram_loader_sum.sv | 42 ++++
 rtl/ram_loader.sv | 178 +++++++++++++++++
 tb/tb_ram_loader.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg
// Shared definitions for the RAM program loader: default geometry of the
// 16x8 program RAM and the loader FSM state encoding.
// Optional feature macro used by the loader: RAM_LOADER_VERIFY_EN.
package ram_loader_pkg;

    localparam int DEPTH_DFLT  = 16;  // words loaded per session
    localparam int ADDR_W_DFLT = 4;   // RAM address width, DEPTH == 2**ADDR_W
    localparam int DATA_W_DFLT = 8;   // RAM word width

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        LOAD        = 3'd1,
        VERIFY_RD   = 3'd2,
        VERIFY_WAIT = 3'd3,
        DONE        = 3'd4
    } state_t;

endpackage

// File: rtl/ram_loader_if.sv
// ram_loader_if
// Bundles the byte-stream input handshake and the RAM write/read port.
//   master : the loader (consumes the byte stream, drives the RAM port)
//   slave  : the environment (byte source and RAM)
// Signals:
//   in_valid/in_data/in_ready : program byte stream
//   ram_w_en/ram_r_en/ram_addr/ram_w_data : RAM strobes, address, write data
//   ram_r_data : registered RAM read data, valid one cycle after ram_r_en
//
// Handshake: a byte transfers on a rising clock edge where in_valid and
// in_ready are both high. The source holds in_valid/in_data stable until
// that edge; in_ready never depends combinationally on in_valid.
interface ram_loader_if
    import ram_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int DATA_W = DATA_W_DFLT
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              ram_w_en;
    logic              ram_r_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_w_data;
    logic [DATA_W-1:0] ram_r_data;

    modport master (
        input  in_valid, in_data, ram_r_data,
        output in_ready, ram_w_en, ram_r_en, ram_addr, ram_w_data
    );

    modport slave (
        output in_valid, in_data, ram_r_data,
        input  in_ready, ram_w_en, ram_r_en, ram_addr, ram_w_data
    );

endinterface

// File: rtl/ram_loader_sum.sv
// ram_loader_sum
// Clearable DATA_W-bit modular accumulator (sum wraps modulo 2**DATA_W).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : clear to zero (has priority over add_i)
//   add_i      : add data_i this cycle
//   data_i     : value to add
//   sum_o      : registered running sum
module ram_loader_sum
    import ram_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              add_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] sum_o
);
    logic [DATA_W-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = '0;
        end else if (add_i) begin
            sum_d = sum_q + data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/ram_loader.sv
// ram_loader
// Loads a DEPTH-word program image from a byte stream into the program RAM,
// holding the CPU halted while it owns the RAM. With RAM_LOADER_VERIFY_EN
// defined, the image is read back afterwards and its sum compared with the
// sum taken during loading; a mismatch raises error.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : level; begins a session in IDLE or DONE
//   bus          : byte stream + RAM port (ram_loader_if.master)
//   cpu_halt     : high while a session is in progress
//   busy         : session in progress
//   done         : session finished (level, cleared by next accepted start)
//   error        : readback sum mismatch (level, cleared by next start)
//   dbg_state_o  : current FSM state
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DFLT,
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int DATA_W = DATA_W_DFLT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    ram_loader_if.master bus,
    output logic         cpu_halt,
    output logic         busy,
    output logic         done,
    output logic         error,
    output state_t       dbg_state_o
);
    // Counter is one bit wider than the address so that reaching DEPTH is a
    // distinct terminal value instead of wrapping back onto address 0.
    localparam logic [ADDR_W:0] CNT_END = (ADDR_W + 1)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              w_en_q, w_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              at_end;

    assign at_end = (count_q == CNT_END);

`ifdef RAM_LOADER_VERIFY_EN
    logic              r_en_q, r_en_d;
    logic              rd_vld_q;
    logic              err_q, err_d;
    logic              start_acc;
    logic [DATA_W-1:0] ck_sum, rs_sum;

    assign start_acc = ((state_q == IDLE) || (state_q == DONE)) && start;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        w_en_d  = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef RAM_LOADER_VERIFY_EN
        r_en_d  = 1'b0;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    count_d = '0;
`ifdef RAM_LOADER_VERIFY_EN
                    err_d   = 1'b0;
`endif
                end
            end
            LOAD: begin
                // The cycle spent at the terminal count lets the final
                // write strobe reach the RAM before the session moves on.
                if (at_end) begin
                    count_d = '0;
`ifdef RAM_LOADER_VERIFY_EN
                    state_d = VERIFY_RD;
`else
                    state_d = DONE;
`endif
                end else if (bus.in_valid) begin
                    w_en_d  = 1'b1;
                    addr_d  = count_q[ADDR_W-1:0];
                    wdata_d = bus.in_data;
                    count_d = count_q + 1'b1;
                end
            end
`ifdef RAM_LOADER_VERIFY_EN
            VERIFY_RD: begin
                if (at_end) begin
                    state_d = VERIFY_WAIT;
                end else begin
                    r_en_d  = 1'b1;
                    addr_d  = count_q[ADDR_W-1:0];
                    count_d = count_q + 1'b1;
                end
            end
            VERIFY_WAIT: begin
                // Last read word is on ram_r_data now; fold it in directly.
                err_d   = ((rs_sum + bus.ram_r_data) != ck_sum);
                state_d = DONE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            w_en_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            w_en_q  <= w_en_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef RAM_LOADER_VERIFY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_q   <= 1'b0;
            rd_vld_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            r_en_q   <= r_en_d;
            rd_vld_q <= r_en_q;  // RAM returns data the cycle after the strobe
            err_q    <= err_d;
        end
    end

    ram_loader_sum #(.DATA_W(DATA_W)) u_checksum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (start_acc),
        .add_i  (w_en_d),
        .data_i (bus.in_data),
        .sum_o  (ck_sum)
    );

    ram_loader_sum #(.DATA_W(DATA_W)) u_readsum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (start_acc),
        .add_i  (rd_vld_q),
        .data_i (bus.ram_r_data),
        .sum_o  (rs_sum)
    );

    assign bus.ram_r_en = r_en_q;
    assign error        = err_q;
`else
    logic unused_r_data;
    assign unused_r_data = ^bus.ram_r_data;
    assign bus.ram_r_en  = 1'b0;
    assign error         = 1'b0;
`endif

    assign bus.in_ready   = (state_q == LOAD) && !at_end;
    assign bus.ram_w_en   = w_en_q;
    assign bus.ram_addr   = addr_q;
    assign bus.ram_w_data = wdata_q;
    assign busy           = (state_q == LOAD) || (state_q == VERIFY_RD) ||
                            (state_q == VERIFY_WAIT);
    assign cpu_halt       = busy;
    assign done           = (state_q == DONE);
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_ram_loader.sv
module tb_ram_loader;
  import ram_loader_pkg::*;

`ifdef RAM_LOADER_VERIFY_EN
  localparam int EXP_LAT = 35;
  localparam int EXP_RD  = 16;
`else
  localparam int EXP_LAT = 17;
  localparam int EXP_RD  = 0;
`endif

  logic   clk;
  logic   rst_n;
  logic   start;
  logic   cpu_halt;
  logic   busy;
  logic   done;
  logic   error;
  state_t dbg_state;

  ram_loader_if bus ();

  ram_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bus         (bus),
    .cpu_halt    (cpu_halt),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters / scoreboard ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [11:0] exp_wr_q[$];  // {addr, data}
  logic [3:0]  exp_rd_q[$];  // read address
  logic [11:0] wr_e;
  logic [3:0]  rd_e;
  int          wr_count = 0;
  int          rd_count = 0;

  logic [7:0]  img [16];
  logic [7:0]  mem [16];
  bit          corrupt7 = 1'b0;
  bit          mem_clr  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- RAM model ----------------
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int a = 0; a < 16; a++) mem[a] <= 8'hEE;
    end else if (bus.ram_w_en) begin
      mem[bus.ram_addr] <= (corrupt7 && bus.ram_addr == 4'd7) ? 8'h00 : bus.ram_w_data;
    end
    if (bus.ram_r_en) bus.ram_r_data <= mem[bus.ram_addr];
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ram_w_en || bus.ram_r_en)
        check("w_r_exclusive", 32'(bus.ram_w_en & bus.ram_r_en), 32'd0);
      if (bus.ram_w_en) begin
        wr_count++;
        if (exp_wr_q.size() == 0) begin
          check("wr_unexpected", 32'({bus.ram_addr, bus.ram_w_data}), 32'hFFFF_FFFF);
        end else begin
          wr_e = exp_wr_q.pop_front();
          check("wr_addr", 32'(bus.ram_addr), 32'(wr_e[11:8]));
          check("wr_data", 32'(bus.ram_w_data), 32'(wr_e[7:0]));
        end
      end
      if (bus.ram_r_en) begin
        rd_count++;
        if (exp_rd_q.size() == 0) begin
          check("rd_unexpected", 32'(bus.ram_addr), 32'hFFFF_FFFF);
        end else begin
          rd_e = exp_rd_q.pop_front();
          check("rd_addr", 32'(bus.ram_addr), 32'(rd_e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_idle(input string name);
    check(name, 32'({bus.in_ready, bus.ram_w_en, bus.ram_r_en, bus.ram_addr,
                     bus.ram_w_data, cpu_halt, busy, done, error}), 32'd0);
    check({name, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  // Called at a negedge; returns at a negedge with in_valid low.
  task automatic send_bytes(input int n, input bit stalls);
    int i = 0;
    int guard = 0;
    logic [3:0] a;
    while (i < n && guard < 400) begin
      if (stalls && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom_range(0, 255));
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = img[i];
      end
      if (bus.in_valid && bus.in_ready) begin
        a = i[3:0];
        exp_wr_q.push_back({a, img[i]});
        i++;
      end
      @(negedge clk);
      guard++;
    end
    bus.in_valid = 1'b0;
    if (i < n) check("send_timeout", 32'(i), 32'(n));
  endtask

  task automatic run_session(input string tag, input bit stalls, input bit exp_err, input int exp_lat);
    int s_cyc;
    int guard;
    int halt_bad;
    logic [7:0] exp_b;
    wr_count = 0;
    rd_count = 0;
    mem_clr = 1'b1;
    @(negedge clk);
    mem_clr = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s_cyc = cyc;
    check({tag, "_started"}, 32'({busy, cpu_halt, done, error}), 32'b1100);
`ifdef RAM_LOADER_VERIFY_EN
    for (int a = 0; a < 16; a++) exp_rd_q.push_back(4'(a));
`endif
    send_bytes(16, stalls);
    // extra offered byte once all 16 are in must not be taken
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    check({tag, "_ready_drop"}, 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    guard = 0;
    halt_bad = 0;
    while (!done && guard < 200) begin
      if (!cpu_halt || !busy) halt_bad++;
      @(negedge clk);
      guard++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    if (exp_lat != 0) check({tag, "_latency"}, 32'(cyc - s_cyc), 32'(exp_lat));
    check({tag, "_halt_in_session"}, 32'(halt_bad), 32'd0);
    check({tag, "_released"}, 32'({busy, cpu_halt}), 32'd0);
    check({tag, "_error"}, 32'(error), 32'(exp_err));
    check({tag, "_wr_count"}, 32'(wr_count), 32'd16);
    check({tag, "_rd_count"}, 32'(rd_count), 32'(EXP_RD));
    check({tag, "_wr_q_empty"}, 32'(exp_wr_q.size()), 32'd0);
    check({tag, "_rd_q_empty"}, 32'(exp_rd_q.size()), 32'd0);
    for (int a = 0; a < 16; a++) begin
      exp_b = (corrupt7 && a == 7) ? 8'h00 : img[a];
      check({tag, "_ram_image"}, 32'(mem[a]), 32'(exp_b));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    for (int i = 0; i < 16; i++) img[i] = 8'h10 + 8'(i);

    repeat (3) @(negedge clk);
    check_idle("reset_asserted");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_idle("reset_idle");
    end

    run_session("b2b", 1'b0, 1'b0, EXP_LAT);
    run_session("stall", 1'b1, 1'b0, 0);

`ifdef RAM_LOADER_VERIFY_EN
    corrupt7 = 1'b1;
    run_session("vfail", 1'b0, 1'b1, EXP_LAT);
    corrupt7 = 1'b0;
`endif

    // abort after byte index 5, mid-session
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_bytes(6, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_idle("abort_async");
    exp_wr_q.delete();
    exp_rd_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("abort_idle");

    run_session("reload", 1'b0, 1'b0, EXP_LAT);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
